alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle arithmetic/logic ops and a
// multi-cycle shift-add unsigned multiplier.
//
// Ports:
//   clk              sole clock, rising edge
//   reset            synchronous active-low reset
//   start            operation request, accepted only while busy=0
//   A, B             WIDTH-bit operands
//   ALUOp            operation select within the arit/logic group
//   arit             1 = arithmetic group, 0 = logic group
//   mul              1 = unsigned multiply (overrides ALUOp/arit)
//   R                2*WIDTH-bit registered result
//   zero/carry/sign/ovf  registered flags
//   busy             high while a multiply is in progress
//   done             one-cycle pulse when R and flags update
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         ALUOp,
    input  logic               arit,
    input  logic               mul,
    output logic [2*WIDTH-1:0] R,
    output logic               zero,
    output logic               carry,
    output logic               sign,
    output logic               ovf,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StMul} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   r_q, r_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 sign_q, sign_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] x, y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] arith_res;
    logic             arith_ovf;
    logic [WIDTH-1:0] logic_res;

    // Multiplier step: {hi, lo} holds partial product in hi and remaining
    // multiplier bits in lo; each step conditionally adds then shifts right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        x   = A;
        y   = B;
        cin = 1'b0;
        // Subtractions are X + ~Y + 1 so carry means "no borrow".
        unique case (ALUOp)
            2'b00: begin
                x   = A;
                y   = B;
                cin = 1'b0;
            end
            2'b01: begin
                x   = A;
                y   = ~B;
                cin = 1'b1;
            end
            2'b10: begin
                x   = B;
                y   = ~A;
                cin = 1'b1;
            end
            default: begin
                x   = '0;
                y   = ~A;
                cin = 1'b1;
            end
        endcase
        sum       = {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(cin);
        arith_res = sum[WIDTH-1:0];
        arith_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (arith_res[WIDTH-1] != x[WIDTH-1]);

        unique case (ALUOp)
            2'b00:   logic_res = A & B;
            2'b01:   logic_res = A | B;
            2'b10:   logic_res = A ^ B;
            default: logic_res = ~A;
        endcase
    end

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        r_d     = r_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (mul) begin
                        state_d = StMul;
                        mcand_d = A;
                        prod_d  = {{WIDTH{1'b0}}, B};
                        cnt_d   = '0;
                    end else begin
                        if (arit) begin
                            r_d     = {{WIDTH{1'b0}}, arith_res};
                            carry_d = sum[WIDTH];
                            ovf_d   = arith_ovf;
                            sign_d  = arith_res[WIDTH-1];
                            zero_d  = (arith_res == '0);
                        end else begin
                            r_d     = {{WIDTH{1'b0}}, logic_res};
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            sign_d  = logic_res[WIDTH-1];
                            zero_d  = (logic_res == '0);
                        end
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    r_d     = mul_next;
                    zero_d  = (mul_next == '0);
                    carry_d = |mul_next[2*WIDTH-1:WIDTH];
                    sign_d  = 1'b0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            r_q     <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign R     = r_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign sign  = sign_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == StMul);
    assign done  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: table of single-cycle ops, then directed
// multiply, abort and back-to-back sequences (WIDTH=8 and WIDTH=4).
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a, b;
    logic [1:0]  op;
    logic        arit, mul;
    logic [15:0] r;
    logic        zero, carry, sign, ovf, busy, done;

    logic        start4;
    logic [3:0]  a4, b4;
    logic [7:0]  r4;
    logic        zero4, carry4, sign4, ovf4, busy4, done4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(rst_n), .start(start), .A(a), .B(b), .ALUOp(op),
        .arit(arit), .mul(mul), .R(r), .zero(zero), .carry(carry), .sign(sign),
        .ovf(ovf), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .A(a4), .B(b4), .ALUOp(2'b00),
        .arit(1'b1), .mul(1'b0), .R(r4), .zero(zero4), .carry(carry4), .sign(sign4),
        .ovf(ovf4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic        arit;
        logic [15:0] r;
        logic        z, c, s, o;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string name, input logic [15:0] er, input logic ez,
                             input logic ec, input logic es, input logic eo);
        chk({name, ".R"}, 32'(r), 32'(er));
        chk({name, ".zero"}, 32'(zero), 32'(ez));
        chk({name, ".carry"}, 32'(carry), 32'(ec));
        chk({name, ".sign"}, 32'(sign), 32'(es));
        chk({name, ".ovf"}, 32'(ovf), 32'(eo));
    endtask

    // Multiply with junk inputs and start pulses while busy; checks exact latency.
    task automatic do_mul(input string name, input logic [7:0] ma, input logic [7:0] mb,
                          input logic [15:0] er);
        logic [15:0] r_before;
        r_before = r;
        a = ma; b = mb; mul = 1'b1; start = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk({name, ".busy"}, 32'(busy), 32'd1);
            chk({name, ".nodone"}, 32'(done), 32'd0);
            chk({name, ".Rhold"}, 32'(r), 32'(r_before));
            a = 8'($urandom); b = 8'($urandom);
            mul = 1'($urandom); start = (k < 7) ? 1'($urandom) : 1'b0;
            tick();
        end
        chk({name, ".done"}, 32'(done), 32'd1);
        chk({name, ".busy_low"}, 32'(busy), 32'd0);
        chk_flags(name, er, er == 16'h0, |er[15:8], 1'b0, 1'b0);
    endtask

    initial begin
        //          a      b      op     arit  r         z     c     s     o
        vecs[0]  = '{8'hFF, 8'h01, 2'b00, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h80, 8'h01, 2'b01, 1'b1, 16'h007F, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{8'h00, 8'h55, 2'b11, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'hF0, 8'hFF, 2'b10, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h7F, 8'h01, 2'b00, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{8'h05, 8'h07, 2'b01, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h03, 8'h0A, 2'b10, 1'b1, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'h01, 8'h00, 2'b11, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'h80, 8'h00, 2'b11, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{8'hCC, 8'hAA, 2'b00, 1'b0, 16'h0088, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h00, 8'h00, 2'b01, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h5A, 8'h00, 2'b11, 1'b0, 16'h00A5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{8'h80, 8'h80, 2'b00, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0; arit = 1'b0; mul = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        tick();
        tick();
        chk_flags("reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-cycle table: done the cycle after the start edge.
        for (int i = 0; i < 13; i++) begin
            a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; arit = vecs[i].arit;
            mul = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            chk($sformatf("vec%0d.done", i), 32'(done), 32'd1);
            chk_flags($sformatf("vec%0d", i), vecs[i].r, vecs[i].z, vecs[i].c,
                      vecs[i].s, vecs[i].o);
        end
        a = 8'h33; b = 8'h44;
        tick();
        chk("hold.done", 32'(done), 32'd0);
        chk_flags("hold", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        do_mul("mulFF", 8'hFF, 8'hFF, 16'hFE01);
        // Next request accepted on the done cycle.
        a = 8'h12; b = 8'h34; op = 2'b00; arit = 1'b1; mul = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("after_mul.done", 32'(done), 32'd1);
        chk_flags("after_mul", 16'h0046, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        do_mul("mul13x11", 8'h0D, 8'h0B, 16'h008F);
        tick();
        do_mul("mul0", 8'h00, 8'h37, 16'h0000);
        tick();
        a = 8'h12; b = 8'h34; op = 2'b00; arit = 1'b1; mul = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pre_abort.R", 32'(r), 32'h46);

        // Abort: reset on the 4th cycle of the multiply.
        a = 8'hFF; b = 8'hFF; mul = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        mul = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk_flags("abort", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        begin
            int seen_done = 0;
            for (int k = 0; k < 12; k++) begin
                if (done) seen_done++;
                tick();
            end
            chk("abort.no_done", 32'(seen_done), 32'd0);
        end

        // Back-to-back, WIDTH=8.
        op = 2'b00; arit = 1'b1; mul = 1'b0; b = 8'h10; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            a = 8'(k);
            tick();
            chk($sformatf("b2b%0d.done", k), 32'(done), 32'd1);
            chk($sformatf("b2b%0d.R", k), 32'(r), 32'(k + 16));
        end
        start = 1'b0;
        tick();
        chk("b2b.end_done", 32'(done), 32'd0);
        chk("b2b.end_R", 32'(r), 32'h14);

        // Back-to-back, WIDTH=4: A = 7,8,9,F with B = 3.
        begin
            logic [3:0] av[4];
            logic [7:0] er[4];
            logic       ec[4];
            av[0] = 4'h7; er[0] = 8'h0A; ec[0] = 1'b0;
            av[1] = 4'h8; er[1] = 8'h0B; ec[1] = 1'b0;
            av[2] = 4'h9; er[2] = 8'h0C; ec[2] = 1'b0;
            av[3] = 4'hF; er[3] = 8'h02; ec[3] = 1'b1;
            b4 = 4'h3; start4 = 1'b1;
            for (int k = 0; k < 4; k++) begin
                a4 = av[k];
                tick();
                chk($sformatf("w4_%0d.done", k), 32'(done4), 32'd1);
                chk($sformatf("w4_%0d.R", k), 32'(r4), 32'(er[k]));
                chk($sformatf("w4_%0d.carry", k), 32'(carry4), 32'(ec[k]));
            end
            start4 = 1'b0;
            tick();
            chk("w4.end_done", 32'(done4), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
